fetch_ibuf: RTL

//  Parametrised instruction buffer between fetch_2 and opcode decode. Accepts one

---
 rtl/fetch_ibuf_if.sv | 43 ++++
 rtl/fetch_ibuf.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fetch_ibuf_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_ibuf_if                                                |
// | Description : Bundle between fetch_2, the instruction buffer and decode.   |
// |               master = fetch/decode side (drives packets, out_ready,       |
// |               resteer); slave = buffer side (drives in_ready, slots,       |
// |               count).                                                      |
// | Ports       : resteer, in_valid/in_ready/in_line/in_pc/in_exception,       |
// |               out_ready/out_valid/out_instr/out_pc/out_exception, count    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fetch_ibuf_if #(
  parameter int XLEN      = 32,
  parameter int CL_SIZE   = 128,
  parameter int DEPTH     = 16,
  parameter int DEC_WIDTH = 2
);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic                      resteer;
  logic                      in_valid;
  logic                      in_ready;
  logic [CL_SIZE-1:0]        in_line;
  logic [XLEN-1:0]           in_pc;
  logic                      in_exception;
  logic                      out_ready;
  logic [DEC_WIDTH-1:0]      out_valid;
  logic [32*DEC_WIDTH-1:0]   out_instr;
  logic [XLEN*DEC_WIDTH-1:0] out_pc;
  logic [DEC_WIDTH-1:0]      out_exception;
  logic [c_cnt_w-1:0]        count;

  modport master (
    output resteer, in_valid, in_line, in_pc, in_exception, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_exception, count
  );

  modport slave (
    input  resteer, in_valid, in_line, in_pc, in_exception, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_exception, count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ibuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_ibuf                                                   |
// | Description : Instruction buffer between fetch_2 and decode. Splits each   |
// |               accepted cache line into 32-bit slots (from the PC offset    |
// |               to the end of the line) and presents up to DEC_WIDTH         |
// |               in-order slots per cycle with PC and exception flag.         |
// | Ports       : clk  - rising-edge clock                                     |
// |               rst  - asynchronous active-low reset                         |
// |               ib   - fetch_ibuf_if.slave (packet in, slots out, count)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_ibuf #(
  parameter int XLEN      = 32,
  parameter int CL_SIZE   = 128,
  parameter int DEPTH     = 16,
  parameter int DEC_WIDTH = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fetch_ibuf_if.slave   ib
);

  localparam int             c_wpl   = CL_SIZE / 32;
  localparam int             c_ptr_w = $clog2(DEPTH);
  localparam int             c_cnt_w = c_ptr_w + 1;
  localparam int             c_off_w = (c_wpl > 1) ? $clog2(c_wpl) : 1;
  localparam logic [31:0]    c_nop   = 32'h0000_0013;

  // Storage
  logic [31:0]        r_instr [DEPTH];
  logic [XLEN-1:0]    r_pc    [DEPTH];
  logic [DEPTH-1:0]   r_exc;
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;

  // Write-side decode
  logic [c_off_w-1:0] w_off;
  logic [c_cnt_w-1:0] w_n;
  logic               w_ready;
  logic               w_push;
  logic [c_cnt_w-1:0] w_pop_k;
  logic [CL_SIZE-1:0] w_line_sh;
  logic [c_wpl-1:0]   w_wr_en;
  logic [31:0]        w_wr_instr [c_wpl];
  logic [XLEN-1:0]    w_wr_pc    [c_wpl];

  // Word offset of the first useful instruction inside the line.
  generate
    if (c_wpl > 1) begin : g_off
      assign w_off = ib.in_pc[c_off_w+1:2];
    end else begin : g_off_single
      assign w_off = '0;
    end
  endgenerate

  // Exception packets always carry exactly one NOP slot.
  assign w_n = ib.in_exception ? c_cnt_w'(1)
                               : (c_cnt_w'(c_wpl) - c_cnt_w'(w_off));

  // Space is judged against a whole line so in_ready never depends on the
  // packet offset or on decode acceptance.
  assign w_ready = (c_cnt_w'(DEPTH) - r_count) >= c_cnt_w'(c_wpl);
  assign w_push  = ib.in_valid & w_ready & ~ib.resteer;

  assign w_pop_k = !ib.out_ready                       ? '0 :
                   (r_count < c_cnt_w'(DEC_WIDTH))     ? r_count :
                                                         c_cnt_w'(DEC_WIDTH);

  // Shift the line so that word 'off' lands at slot 0 of the write window.
  assign w_line_sh = ib.in_line >> {w_off, 5'd0};

  always_comb begin
    w_wr_en = '0;
    for (int j = 0; j < c_wpl; j++) begin
      w_wr_en[j]    = w_push && (c_cnt_w'(j) < w_n);
      w_wr_instr[j] = ib.in_exception ? c_nop : w_line_sh[32*j +: 32];
      w_wr_pc[j]    = ib.in_pc + XLEN'(4 * j);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_exc   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (ib.resteer) begin
      // Stale entries are left in place; the pointers alone invalidate them.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int j = 0; j < c_wpl; j++) begin
        if (w_wr_en[j]) begin
          r_instr[r_tail + c_ptr_w'(j)] <= w_wr_instr[j];
          r_pc[r_tail + c_ptr_w'(j)]    <= w_wr_pc[j];
          r_exc[r_tail + c_ptr_w'(j)]   <= ib.in_exception;
        end
      end
      r_head  <= r_head + c_ptr_w'(w_pop_k);
      r_tail  <= r_tail + (w_push ? c_ptr_w'(w_n) : c_ptr_w'(0));
      r_count <= r_count + (w_push ? w_n : c_cnt_w'(0)) - w_pop_k;
    end
  end

  // Read side: slot i is simply entry head+i; valid is thermometer from count.
  always_comb begin
    ib.out_valid     = '0;
    ib.out_instr     = '0;
    ib.out_pc        = '0;
    ib.out_exception = '0;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      ib.out_valid[i]             = r_count > c_cnt_w'(i);
      ib.out_instr[32*i +: 32]    = r_instr[r_head + c_ptr_w'(i)];
      ib.out_pc[XLEN*i +: XLEN]   = r_pc[r_head + c_ptr_w'(i)];
      ib.out_exception[i]         = r_exc[r_head + c_ptr_w'(i)];
    end
  end

  assign ib.in_ready = w_ready;
  assign ib.count    = r_count;

endmodule
`default_nettype wire
